// File: rtl/fasm_dpsram_be_if.sv
// Bus bundle for the dual-port byte-enable RAM: port A and port X access signals.
// The master drives addresses, data, lane selects and strobes; the slave returns read data and acks.
interface fasm_dpsram_be_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    localparam int SW = DW / 8;

    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic [SW-1:0] sel_i;
    logic          wre_i;
    logic          stb_i;
    logic [DW-1:0] dat_o;
    logic          ack_o;

    logic [AW-1:0] xadr_i;
    logic [DW-1:0] xdat_i;
    logic [SW-1:0] xsel_i;
    logic          xwre_i;
    logic          xstb_i;
    logic [DW-1:0] xdat_o;
    logic          xack_o;

    modport master (
        output adr_i, dat_i, sel_i, wre_i, stb_i,
        output xadr_i, xdat_i, xsel_i, xwre_i, xstb_i,
        input  dat_o, ack_o, xdat_o, xack_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, wre_i, stb_i,
        input  xadr_i, xdat_i, xsel_i, xwre_i, xstb_i,
        output dat_o, ack_o, xdat_o, xack_o
    );
endinterface

// File: rtl/fasm_dpsram_be.sv
// Single-clock true dual-port RAM with per-byte write enables, always-ready ports,
// an ack pipeline of 1+OREG cycles and deterministic same-address collision rules.
module fasm_dpsram_be #(
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int OREG  = 0,
    parameter int WMODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fasm_dpsram_be_if.slave   bus
);
    localparam int SW    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    logic          a_wr;
    logic          x_wr;
    logic          same_adr;
    logic [DW-1:0] a_new;
    logic [DW-1:0] x_new;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] x_rdata;

    logic          ack1;
    logic          xack1;
    logic [DW-1:0] dat1;
    logic [DW-1:0] xdat1;

    // Strobes are ignored while reset is held, so writes are gated by rst_i too.
    assign a_wr     = bus.stb_i  & bus.wre_i  & rst_i;
    assign x_wr     = bus.xstb_i & bus.xwre_i & rst_i;
    assign same_adr = (bus.adr_i == bus.xadr_i);

    // NOTE: the storage array is never reset; only the pipeline registers are.
    // X lanes are written first so that A's later assignment wins on shared lanes.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < SW; k++) begin
            if (x_wr && bus.xsel_i[k]) mem[bus.xadr_i][8*k +: 8] <= bus.xdat_i[8*k +: 8];
            if (a_wr && bus.sel_i[k])  mem[bus.adr_i][8*k +: 8]  <= bus.dat_i[8*k +: 8];
        end
    end

    // Word each port will see after this edge's writes, with A taking priority.
    always_comb begin
        a_new = mem[bus.adr_i];
        x_new = mem[bus.xadr_i];
        for (int k = 0; k < SW; k++) begin
            if (x_wr && bus.xsel_i[k]) begin
                x_new[8*k +: 8] = bus.xdat_i[8*k +: 8];
                if (same_adr) a_new[8*k +: 8] = bus.xdat_i[8*k +: 8];
            end
            if (a_wr && bus.sel_i[k]) begin
                a_new[8*k +: 8] = bus.dat_i[8*k +: 8];
                if (same_adr) x_new[8*k +: 8] = bus.dat_i[8*k +: 8];
            end
        end
    end

    assign a_rdata = (WMODE == 0) ? a_new : mem[bus.adr_i];
    assign x_rdata = (WMODE == 0) ? x_new : mem[bus.xadr_i];

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack1  <= 1'b0;
            xack1 <= 1'b0;
            dat1  <= '0;
            xdat1 <= '0;
        end else begin
            ack1  <= bus.stb_i;
            xack1 <= bus.xstb_i;
            if (bus.stb_i)  dat1  <= a_rdata;
            if (bus.xstb_i) xdat1 <= x_rdata;
        end
    end

    if (OREG != 0) begin : g_oreg
        logic          ack2;
        logic          xack2;
        logic [DW-1:0] dat2;
        logic [DW-1:0] xdat2;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                ack2  <= 1'b0;
                xack2 <= 1'b0;
                dat2  <= '0;
                xdat2 <= '0;
            end else begin
                ack2  <= ack1;
                xack2 <= xack1;
                if (ack1)  dat2  <= dat1;
                if (xack1) xdat2 <= xdat1;
            end
        end

        assign bus.ack_o  = ack2;
        assign bus.xack_o = xack2;
        assign bus.dat_o  = dat2;
        assign bus.xdat_o = xdat2;
    end else begin : g_direct
        assign bus.ack_o  = ack1;
        assign bus.xack_o = xack1;
        assign bus.dat_o  = dat1;
        assign bus.xdat_o = xdat1;
    end
endmodule

// File: tb/tb_fasm_dpsram_be.sv
// Scoreboard bench for fasm_dpsram_be: four instances (OREG x WMODE) share stimulus,
// expected responses are queued at issue and popped by a negedge monitor.
module tb_fasm_dpsram_be;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int NCFG = 4;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        bit          care;
    } sb_t;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0]  adr, xadr;
    logic [31:0] dat, xdat;
    logic [3:0]  sel, xsel;
    logic        wre, stb, xwre, xstb;

    logic [31:0] dat_o_v  [NCFG];
    logic [31:0] xdat_o_v [NCFG];
    logic        ack_o_v  [NCFG];
    logic        xack_o_v [NCFG];

    sb_t         exp_q [2*NCFG][$];
    logic [31:0] last  [2*NCFG];
    logic [31:0] ref_mem [256];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        fasm_dpsram_be_if #(.AW(AW), .DW(DW)) bus ();
        assign bus.adr_i  = adr;
        assign bus.dat_i  = dat;
        assign bus.sel_i  = sel;
        assign bus.wre_i  = wre;
        assign bus.stb_i  = stb;
        assign bus.xadr_i = xadr;
        assign bus.xdat_i = xdat;
        assign bus.xsel_i = xsel;
        assign bus.xwre_i = xwre;
        assign bus.xstb_i = xstb;
        assign dat_o_v[g]  = bus.dat_o;
        assign ack_o_v[g]  = bus.ack_o;
        assign xdat_o_v[g] = bus.xdat_o;
        assign xack_o_v[g] = bus.xack_o;

        fasm_dpsram_be #(.AW(AW), .DW(DW), .OREG(g / 2), .WMODE(g % 2)) u_dut (
            .clk_i (clk_i),
            .rst_i (rst_n),
            .bus   (bus)
        );
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg=%0d port=%s got=%h exp=%h t=%0t",
                     name, idx / 2, (idx % 2) ? "X" : "A", act, exp, $time);
        end
    endtask

    // Monitor: any ack must match the head of that port's queue in cycle and data.
    always @(negedge clk_i) begin : monitor
        logic        a;
        logic        exp_ack;
        logic [31:0] d;
        sb_t         e;
        if (rst_n) begin
            for (int i = 0; i < 2*NCFG; i++) begin
                a = (i % 2 == 1) ? xack_o_v[i/2] : ack_o_v[i/2];
                d = (i % 2 == 1) ? xdat_o_v[i/2] : dat_o_v[i/2];
                exp_ack = 1'b0;
                if (exp_q[i].size() > 0) exp_ack = (exp_q[i][0].cyc == cyc);
                check("ack", i, 32'(a), 32'(exp_ack));
                if (exp_ack) begin
                    e = exp_q[i].pop_front();
                    if (a && e.care) check("rdata", i, d, e.d);
                end
                if (a) last[i] = d;
                else   check("hold", i, d, last[i]);
            end
        end
    end

    task automatic drive(input logic as, input logic aw, input logic [7:0] aa, input logic [31:0] ad,
                         input logic [3:0] asl,
                         input logic xs, input logic xw, input logic [7:0] xa, input logic [31:0] xd,
                         input logic [3:0] xsl,
                         input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] ex0, input logic [31:0] ex1, input bit c1);
        @(negedge clk_i);
        stb = as; wre = aw; adr = aa; dat = ad; sel = asl;
        xstb = xs; xwre = xw; xadr = xa; xdat = xd; xsel = xsl;
        for (int g = 0; g < NCFG; g++) begin
            if (as) exp_q[2*g].push_back('{cyc + 1 + g/2, (g % 2 == 1) ? ea1 : ea0, (g % 2 == 1) ? c1 : 1'b1});
            if (xs) exp_q[2*g+1].push_back('{cyc + 1 + g/2, (g % 2 == 1) ? ex1 : ex0, (g % 2 == 1) ? c1 : 1'b1});
        end
    endtask

    task automatic a_op(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] e0, input logic [31:0] e1, input bit c1);
        drive(1'b1, w, a, d, s, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, e0, e1, 32'h0, 32'h0, c1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0,
                         32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic chk_zero(input string name);
        for (int g = 0; g < NCFG; g++) begin
            check({name, "_ack"}, 2*g,   32'(ack_o_v[g]),  32'h0);
            check({name, "_dat"}, 2*g,   dat_o_v[g],       32'h0);
            check({name, "_ack"}, 2*g+1, 32'(xack_o_v[g]), 32'h0);
            check({name, "_dat"}, 2*g+1, xdat_o_v[g],      32'h0);
        end
    endtask

    // Array-level reference: pre-write words, then X lanes, then A lanes on top.
    task automatic model(input logic as, input logic aw, input logic [7:0] aa, input logic [31:0] ad,
                         input logic [3:0] asl,
                         input logic xs, input logic xw, input logic [7:0] xa, input logic [31:0] xd,
                         input logic [3:0] xsl,
                         output logic [31:0] ea0, output logic [31:0] ea1,
                         output logic [31:0] ex0, output logic [31:0] ex1);
        ea1 = ref_mem[aa];
        ex1 = ref_mem[xa];
        for (int k = 0; k < 4; k++)
            if (xs && xw && xsl[k]) ref_mem[xa][8*k +: 8] = xd[8*k +: 8];
        for (int k = 0; k < 4; k++)
            if (as && aw && asl[k]) ref_mem[aa][8*k +: 8] = ad[8*k +: 8];
        ea0 = ref_mem[aa];
        ex0 = ref_mem[xa];
    endtask

    initial begin : main
        logic        as_, aw_, xs_, xw_;
        logic [7:0]  aa, xa;
        logic [31:0] ad, xd, ea0, ea1, ex0, ex1;
        logic [3:0]  asl, xsl;

        stb = 0; wre = 0; adr = 0; dat = 0; sel = 0;
        xstb = 0; xwre = 0; xadr = 0; xdat = 0; xsel = 0;
        for (int i = 0; i < 2*NCFG; i++) last[i] = 32'h0;

        repeat (3) @(negedge clk_i);
        chk_zero("reset_state");
        rst_n = 1'b1;
        idle(2);

        // Byte-lane write and read-during-write on the same port.
        a_op(1'b1, 8'h05, 32'h11223344, 4'hF,   32'h11223344, 32'h0,        1'b0);
        a_op(1'b1, 8'h05, 32'hAABBCCDD, 4'b0010, 32'h1122CC44, 32'h11223344, 1'b1);
        a_op(1'b0, 8'h05, 32'h0,        4'h0,   32'h1122CC44, 32'h1122CC44, 1'b1);

        // Fill 0..7, then eight back-to-back reads.
        for (int i = 0; i < 8; i++)
            a_op(1'b1, 8'(i), 32'hC0DE0000 | i, 4'hF, 32'hC0DE0000 | i, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            a_op(1'b0, 8'(i), 32'h0, 4'h0, 32'hC0DE0000 | i, 32'hC0DE0000 | i, 1'b1);

        // Prepare 0x10 = 0 and 0x20 = 1 (X port writes).
        drive(0, 0, 8'h0, 32'h0, 4'h0, 1, 1, 8'h10, 32'h0, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        drive(0, 0, 8'h0, 32'h0, 4'h0, 1, 1, 8'h20, 32'h1, 4'hF, 32'h0, 32'h0, 32'h1, 32'h0, 1'b0);
        idle(1);

        // Write/write collision, then both ports read the merged word.
        drive(1, 1, 8'h10, 32'hAAAAAAAA, 4'b0011, 1, 1, 8'h10, 32'hBBBBBBBB, 4'b0110,
              32'h00BBAAAA, 32'h0, 32'h00BBAAAA, 32'h0, 1'b1);
        drive(1, 0, 8'h10, 32'h0, 4'h0, 1, 0, 8'h10, 32'h0, 4'h0,
              32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 1'b1);

        // Read/write collision at 0x20.
        drive(1, 0, 8'h20, 32'h0, 4'h0, 1, 1, 8'h20, 32'h2, 4'hF,
              32'h2, 32'h1, 32'h2, 32'h1, 1'b1);
        drive(1, 0, 8'h20, 32'h0, 4'h0, 1, 0, 8'h20, 32'h0, 4'h0,
              32'h2, 32'h2, 32'h2, 32'h2, 1'b1);
        idle(3);

        // Reset mid-burst with acks in flight; the writes themselves must persist.
        a_op(1'b1, 8'h30, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        a_op(1'b1, 8'h31, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);
        @(posedge clk_i);
        #2;
        rst_n = 1'b0;
        stb = 1'b0;
        #1;
        chk_zero("reset_async");
        for (int i = 0; i < 2*NCFG; i++) begin
            exp_q[i].delete();
            last[i] = 32'h0;
        end
        // Strobes during reset must not write.
        @(negedge clk_i);
        adr = 8'h30; dat = 32'hFFFFFFFF; sel = 4'hF; wre = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk_i);
        stb = 1'b0; wre = 1'b0;
        chk_zero("reset_hold");
        #1;
        rst_n = 1'b1;
        idle(4);
        a_op(1'b0, 8'h30, 32'h0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        a_op(1'b0, 8'h31, 32'h0, 4'h0, 32'h0BADF00D, 32'h0BADF00D, 1'b1);
        idle(3);

        // Random concurrent traffic over 0x40..0x47 against the array model.
        for (int i = 0; i < 8; i++) begin
            model(1, 1, 8'h40 + 8'(i), 32'h5A000000 | i, 4'hF, 0, 0, 8'h0, 32'h0, 4'h0, ea0, ea1, ex0, ex1);
            a_op(1'b1, 8'h40 + 8'(i), 32'h5A000000 | i, 4'hF, ea0, ea1, 1'b0);
        end
        for (int n = 0; n < 80; n++) begin
            as_ = 1'($urandom_range(0, 1));
            aw_ = 1'($urandom_range(0, 1));
            xs_ = 1'($urandom_range(0, 1));
            xw_ = 1'($urandom_range(0, 1));
            aa  = 8'h40 + 8'($urandom_range(0, 7));
            xa  = 8'h40 + 8'($urandom_range(0, 7));
            ad  = $urandom;
            xd  = $urandom;
            asl = 4'($urandom_range(0, 15));
            xsl = 4'($urandom_range(0, 15));
            model(as_, aw_, aa, ad, asl, xs_, xw_, xa, xd, xsl, ea0, ea1, ex0, ex1);
            drive(as_, aw_, aa, ad, asl, xs_, xw_, xa, xd, xsl, ea0, ea1, ex0, ex1, 1'b1);
        end
        idle(5);

        for (int i = 0; i < 2*NCFG; i++) check("drained", i, 32'(exp_q[i].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
